wam_kbd: RTL



---
 rtl/wam_pkg.sv | 14 +
 rtl/wam_kbd_if.sv | 16 +
 rtl/wam_dbc.sv | 59 +++++
 rtl/wam_kbd.sv | 55 +++++
 4 files changed

// File: rtl/wam_pkg.sv
// wam_pkg: shared constants and types for the whack-a-mole input and display paths.
//   N_HOLES     : number of holes (one hit input and one LED per hole)
//   DB_CNT_DEF  : default debounce length in cycles
//   DB_W_DEF    : default debounce counter width (2**DB_W_DEF > DB_CNT_DEF)
//   hole_vec_t  : one bit per hole, shared with the LED/display blocks
package wam_pkg;

    localparam int unsigned N_HOLES    = 8;
    localparam int unsigned DB_CNT_DEF = 50000;
    localparam int unsigned DB_W_DEF   = 16;

    typedef logic [N_HOLES-1:0] hole_vec_t;

endpackage

// File: rtl/wam_kbd_if.sv
// wam_kbd_if: hit snapshot handshake between the keyboard front end and the game core.
//   hits      : sticky set of holes pressed since the last ack
//   hit_valid : |hits
//   hit_ack   : consumer takes the current snapshot (clears it on the next edge)
// Modports: master = keyboard block, slave = game core.
interface wam_kbd_if;
    import wam_pkg::*;

    hole_vec_t hits;
    logic      hit_valid;
    logic      hit_ack;

    modport master (output hits, output hit_valid, input hit_ack);
    modport slave  (input hits, input hit_valid, output hit_ack);

endinterface

// File: rtl/wam_dbc.sv
// wam_dbc: one hit channel -- two-flop synchronizer, debounce counter, stable level
// and a one-cycle press pulse on each debounced 0->1 transition.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_in     : raw asynchronous input, 1 = pressed
//   key        : debounced (stable) level
//   press      : registered pulse, high for one cycle as key rises
module wam_dbc #(
    parameter int unsigned DB_CNT = 50000,
    parameter int unsigned DB_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key,
    output logic press
);

    localparam logic [DB_W-1:0] CntMax = DB_W'(DB_CNT - 1);

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            press_q;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The level flips on the DB_CNT-th consecutive disagreeing cycle; any agreeing
    // cycle restarts the count, so cnt never passes CntMax.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= key_in;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= ~stable_q & stable_d;
        end
    end

    assign key   = stable_q;
    assign press = press_q;

endmodule

// File: rtl/wam_kbd.sv
// wam_kbd: hole-hit keyboard front end. Debounces every hit input, turns debounced
// presses into pulses and accumulates them in a sticky register drained by the game
// core through a valid/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_in     : raw hit inputs, 1 = pressed
//   keys       : debounced level per hole
//   press      : one-cycle pulse per hole on a debounced press
//   hit_bus    : hits / hit_valid / hit_ack handshake (master side)
module wam_kbd
    import wam_pkg::*;
#(
    parameter int unsigned DB_CNT = DB_CNT_DEF,
    parameter int unsigned DB_W   = DB_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  hole_vec_t         key_in,
    output hole_vec_t         keys,
    output hole_vec_t         press,
    wam_kbd_if.master         hit_bus
);

    hole_vec_t hits_q, hits_d;

    for (genvar i = 0; i < N_HOLES; i++) begin : g_chan
        wam_dbc #(
            .DB_CNT (DB_CNT),
            .DB_W   (DB_W)
        ) u_dbc (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_in (key_in[i]),
            .key    (keys[i]),
            .press  (press[i])
        );
    end

    // Ack clears the old snapshot, but a press landing in the ack cycle survives.
    always_comb begin
        hits_d = (hit_bus.hit_valid && hit_bus.hit_ack) ? '0 : hits_q;
        hits_d = hits_d | press;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign hit_bus.hits      = hits_q;
    assign hit_bus.hit_valid = |hits_q;

endmodule
